instr_fetch: RTL



---
 rtl/instr_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and
// fills the IF/ID register, with stall, redirect, EBREAK halt and misaligned-target trap.
module instr_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_id_valid,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic                  halted,
  output logic                  fetch_err,
  output logic [31:0]           fetch_count
);

  localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);
  localparam logic [ADDR_WIDTH-1:0] FOUR   = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [ADDR_WIDTH-1:0]   id_pc4_q, id_pc4_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [31:0]             count_q, count_d;
  logic                    redirect_aligned;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    instr_d  = instr_q;
    count_d  = count_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          vld_d   = 1'b0;
          instr_d = NOP;
          if (redirect_aligned) pc_d = redirect_pc;
          else                  state_d = TRAP;
        end else if (!stall) begin
          id_pc_d  = pc_q;
          id_pc4_d = pc_q + FOUR;
          instr_d  = imem_dout;
          vld_d    = 1'b1;
          count_d  = sat_inc(count_q);
          // EBREAK is delivered but the PC parks on it until a redirect arrives.
          if (imem_dout == EBREAK) state_d = HALT;
          else                     pc_d = pc_q + FOUR;
        end
      end
      HALT: begin
        vld_d   = 1'b0;
        instr_d = NOP;
        if (redirect_valid) begin
          if (redirect_aligned) begin
            state_d = RUN;
            pc_d    = redirect_pc;
          end else begin
            state_d = TRAP;
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        instr_d = NOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      vld_q    <= 1'b0;
      id_pc_q  <= '0;
      id_pc4_q <= '0;
      instr_q  <= NOP;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      instr_q  <= instr_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = vld_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_instr    = instr_q;
  assign halted         = (state_q == HALT);
  assign fetch_err      = (state_q == TRAP);
  assign fetch_count    = count_q;

endmodule
